// File: rtl/n64adv2_vout_stage.sv
// n64adv2_vout_stage: output stage towards the ADV7513 pads.
// Data/DE travel a fixed pipeline, syncs travel a longer delay line with a
// run-time tap, and blanking/mute/inversion are applied in the output register.
// Run-time configuration is shadowed and only switches at a VSYNC rising edge.
module n64adv2_vout_stage #(
  parameter int COLOR_W    = 8,
  parameter int N_CH       = 3,
  parameter int PIPE_DEPTH = 2,
  parameter int SKEW_W     = 3
) (
  input  logic                      HDMI_CLK_w,
  input  logic                      HDMI_nRST_w,
  input  logic                      VSYNC_i,
  input  logic                      HSYNC_i,
  input  logic                      DE_i,
  input  logic [N_CH*COLOR_W-1:0]   VD_i,
  input  logic [SKEW_W-1:0]         sync_skew_i,
  input  logic                      vs_inv_i,
  input  logic                      hs_inv_i,
  input  logic                      limited_range_i,
  input  logic                      mute_req_i,
  output logic                      mute_ack_o,
  output logic                      VSYNC_o,
  output logic                      HSYNC_o,
  output logic                      DE_o,
  output logic [N_CH*COLOR_W-1:0]   VD_o
);

  localparam int VD_W     = N_CH * COLOR_W;
  localparam int SKEW_MAX = (2 ** SKEW_W) - 1;
  // Sync line length up to the output register; the output register is the last stage.
  localparam int SLEN     = PIPE_DEPTH + SKEW_MAX;
  localparam int SDLY     = SLEN - 1;
  localparam logic [COLOR_W-1:0] BLANK_LR = COLOR_W'(16 << (COLOR_W - 8));

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    MUTE_PEND   = 2'd1,
    MUTED       = 2'd2,
    UNMUTE_PEND = 2'd3
  } mute_state_t;

  // Per-channel blanking level: video black in limited range, zero in full range.
  function automatic logic [VD_W-1:0] blank_value(input logic lr);
    logic [VD_W-1:0] v;
    v = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      v[ch*COLOR_W +: COLOR_W] = lr ? BLANK_LR : '0;
    end
    return v;
  endfunction

  logic              vs_prev;
  logic              vs_edge;
  logic [SKEW_W-1:0] skew_act;
  logic [SKEW_W-1:0] skew_sel;
  logic              vs_inv_act;
  logic              hs_inv_act;
  logic              lr_act;
  mute_state_t       mute_st;
  logic              mute_in;
  logic              vld_src;
  logic [VD_W-1:0]   vd_src;
  logic              mute_src;
  logic [SDLY-1:0]   vs_dly;
  logic [SDLY-1:0]   hs_dly;
  logic              vs_tap;
  logic              hs_tap;

  assign vs_edge  = VSYNC_i & ~vs_prev;
  // The new skew selects its tap already in the edge cycle.
  assign skew_sel = vs_edge ? sync_skew_i : skew_act;
  // Mute flag from the pre-transition state so it flips on the first pixel after the edge.
  assign mute_in  = (mute_st == MUTED) || (mute_st == UNMUTE_PEND);

  // Input-side VSYNC history and frame-aligned configuration shadow.
  always_ff @(posedge HDMI_CLK_w or negedge HDMI_nRST_w) begin
    if (!HDMI_nRST_w) begin
      vs_prev    <= 1'b0;
      skew_act   <= '0;
      vs_inv_act <= 1'b0;
      hs_inv_act <= 1'b0;
      lr_act     <= 1'b0;
    end else begin
      vs_prev <= VSYNC_i;
      if (vs_edge) begin
        skew_act   <= sync_skew_i;
        vs_inv_act <= vs_inv_i;
        hs_inv_act <= hs_inv_i;
        lr_act     <= limited_range_i;
      end
    end
  end

  // Mute handshake: requests and releases only take hold at a frame boundary.
  always_ff @(posedge HDMI_CLK_w or negedge HDMI_nRST_w) begin
    if (!HDMI_nRST_w) begin
      mute_st    <= RUN;
      mute_ack_o <= 1'b0;
    end else begin
      mute_ack_o <= (mute_st == MUTED) || (mute_st == UNMUTE_PEND);
      case (mute_st)
        RUN: begin
          if (mute_req_i) mute_st <= MUTE_PEND;
        end
        MUTE_PEND: begin
          if (!mute_req_i)  mute_st <= RUN;
          else if (vs_edge) mute_st <= MUTED;
        end
        MUTED: begin
          if (!mute_req_i) mute_st <= UNMUTE_PEND;
        end
        UNMUTE_PEND: begin
          if (mute_req_i)   mute_st <= MUTED;
          else if (vs_edge) mute_st <= RUN;
        end
        default: mute_st <= RUN;
      endcase
    end
  end

  generate
    if (PIPE_DEPTH > 1) begin : g_pre
      logic            vld_p  [PIPE_DEPTH-1];
      logic [VD_W-1:0] vd_p   [PIPE_DEPTH-1];
      logic            mute_p [PIPE_DEPTH-1];

      // Stages p0..p(N-2): DE, pixel and mute flag shift together ahead of the output register.
      always_ff @(posedge HDMI_CLK_w or negedge HDMI_nRST_w) begin
        if (!HDMI_nRST_w) begin
          for (int k = 0; k < PIPE_DEPTH - 1; k++) begin
            vld_p[k]  <= 1'b0;
            vd_p[k]   <= '0;
            mute_p[k] <= 1'b0;
          end
        end else begin
          vld_p[0]  <= DE_i;
          vd_p[0]   <= VD_i;
          mute_p[0] <= mute_in;
          for (int k = 1; k < PIPE_DEPTH - 1; k++) begin
            vld_p[k]  <= vld_p[k-1];
            vd_p[k]   <= vd_p[k-1];
            mute_p[k] <= mute_p[k-1];
          end
        end
      end

      assign vld_src  = vld_p[PIPE_DEPTH-2];
      assign vd_src   = vd_p[PIPE_DEPTH-2];
      assign mute_src = mute_p[PIPE_DEPTH-2];
    end else begin : g_nopre
      assign vld_src  = DE_i;
      assign vd_src   = VD_i;
      assign mute_src = mute_in;
    end
  endgenerate

  // Sync delay line, one register per cycle of possible delay before the output stage.
  always_ff @(posedge HDMI_CLK_w or negedge HDMI_nRST_w) begin
    if (!HDMI_nRST_w) begin
      vs_dly <= '0;
      hs_dly <= '0;
    end else begin
      vs_dly[0] <= VSYNC_i;
      hs_dly[0] <= HSYNC_i;
      for (int k = 1; k < SDLY; k++) begin
        vs_dly[k] <= vs_dly[k-1];
        hs_dly[k] <= hs_dly[k-1];
      end
    end
  end

  // Tap k holds the input from k cycles ago; tap 0 is the live input.
  always_comb begin
    int tap_sel;
    tap_sel = PIPE_DEPTH - 1 + int'(skew_sel);
    vs_tap  = VSYNC_i;
    hs_tap  = HSYNC_i;
    for (int k = 1; k <= SDLY; k++) begin
      if (tap_sel == k) begin
        vs_tap = vs_dly[k-1];
        hs_tap = hs_dly[k-1];
      end
    end
  end

  // Output register: polarity, DE passthrough and blanking of inactive or muted pixels.
  always_ff @(posedge HDMI_CLK_w or negedge HDMI_nRST_w) begin
    if (!HDMI_nRST_w) begin
      VSYNC_o <= 1'b0;
      HSYNC_o <= 1'b0;
      DE_o    <= 1'b0;
      VD_o    <= '0;
    end else begin
      VSYNC_o <= vs_tap ^ vs_inv_act;
      HSYNC_o <= hs_tap ^ hs_inv_act;
      DE_o    <= vld_src;
      VD_o    <= (!vld_src || mute_src) ? blank_value(lr_act) : vd_src;
    end
  end

endmodule

// File: tb/tb_n64adv2_vout_stage.sv
// Directed bench for n64adv2_vout_stage with default parameters
// (COLOR_W=8, N_CH=3, PIPE_DEPTH=2, SKEW_W=3).
module tb_n64adv2_vout_stage;

  logic        HDMI_CLK_w = 1'b0;
  logic        HDMI_nRST_w;
  logic        VSYNC_i, HSYNC_i, DE_i;
  logic [23:0] VD_i;
  logic [2:0]  sync_skew_i;
  logic        vs_inv_i, hs_inv_i, limited_range_i, mute_req_i;
  logic        mute_ack_o, VSYNC_o, HSYNC_o, DE_o;
  logic [23:0] VD_o;

  int n_chk  = 0;
  int n_fail = 0;

  n64adv2_vout_stage #(
    .COLOR_W(8), .N_CH(3), .PIPE_DEPTH(2), .SKEW_W(3)
  ) dut (
    .HDMI_CLK_w      (HDMI_CLK_w),
    .HDMI_nRST_w     (HDMI_nRST_w),
    .VSYNC_i         (VSYNC_i),
    .HSYNC_i         (HSYNC_i),
    .DE_i            (DE_i),
    .VD_i            (VD_i),
    .sync_skew_i     (sync_skew_i),
    .vs_inv_i        (vs_inv_i),
    .hs_inv_i        (hs_inv_i),
    .limited_range_i (limited_range_i),
    .mute_req_i      (mute_req_i),
    .mute_ack_o      (mute_ack_o),
    .VSYNC_o         (VSYNC_o),
    .HSYNC_o         (HSYNC_o),
    .DE_o            (DE_o),
    .VD_o            (VD_o)
  );

  always #5 HDMI_CLK_w = ~HDMI_CLK_w;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge HDMI_CLK_w);
      #1;
    end
  endtask

  task automatic vs_pulse();
    VSYNC_i = 1'b1;
    step(1);
    VSYNC_i = 1'b0;
  endtask

  initial begin
    HDMI_nRST_w = 1'b0;
    VSYNC_i = 1'b1; HSYNC_i = 1'b1; DE_i = 1'b1; VD_i = 24'hABCDEF;
    sync_skew_i = 3'd0; vs_inv_i = 1'b1; hs_inv_i = 1'b1;
    limited_range_i = 1'b1; mute_req_i = 1'b1;
    step(4);
    chk("rst_vd",  32'(VD_o), 32'h0);
    chk("rst_de",  32'(DE_o), 32'h0);
    chk("rst_hs",  32'(HSYNC_o), 32'h0);
    chk("rst_vs",  32'(VSYNC_o), 32'h0);
    chk("rst_ack", 32'(mute_ack_o), 32'h0);

    // Release with quiet inputs, then one pixel through a 2-cycle pipeline.
    VSYNC_i = 0; HSYNC_i = 0; DE_i = 0; VD_i = 0;
    vs_inv_i = 0; hs_inv_i = 0; limited_range_i = 0; mute_req_i = 0;
    HDMI_nRST_w = 1'b1;
    step(2);
    DE_i = 1; VD_i = 24'hABCDEF;
    step(1);
    DE_i = 0; VD_i = 24'h0;
    chk("lat1_vd", 32'(VD_o), 32'h0);
    chk("lat1_de", 32'(DE_o), 32'h0);
    step(1);
    chk("lat2_vd", 32'(VD_o), 32'hABCDEF);
    chk("lat2_de", 32'(DE_o), 32'h1);
    step(1);
    chk("lat3_de", 32'(DE_o), 32'h0);

    // Skew 3: sync latency 5, DE latency stays 2.
    sync_skew_i = 3'd3;
    vs_pulse();
    step(3);
    chk("vs_skew4", 32'(VSYNC_o), 32'h0);
    step(1);
    chk("vs_skew5", 32'(VSYNC_o), 32'h1);
    step(4);
    HSYNC_i = 1; DE_i = 1; VD_i = 24'h010203;
    step(1);
    HSYNC_i = 0; DE_i = 0;
    step(1);
    chk("skew_de2", 32'(DE_o), 32'h1);
    chk("skew_hs2", 32'(HSYNC_o), 32'h0);
    step(2);
    chk("skew_hs4", 32'(HSYNC_o), 32'h0);
    step(1);
    chk("skew_hs5", 32'(HSYNC_o), 32'h1);
    step(1);
    chk("skew_hs6", 32'(HSYNC_o), 32'h0);

    // Inversion requested mid-frame only applies after the next frame edge.
    hs_inv_i = 1;
    step(3);
    chk("hsinv_mid", 32'(HSYNC_o), 32'h0);
    vs_pulse();
    step(8);
    chk("hsinv_on", 32'(HSYNC_o), 32'h1);
    chk("vsinv_off", 32'(VSYNC_o), 32'h0);

    // Limited-range blanking, shadowed across a mid-frame change.
    limited_range_i = 1;
    vs_pulse();
    step(8);
    DE_i = 0; VD_i = 24'hFFFFFF;
    step(2);
    chk("lr_blank", 32'(VD_o), 32'h101010);
    DE_i = 1; VD_i = 24'h123456;
    step(2);
    chk("lr_pix", 32'(VD_o), 32'h123456);
    DE_i = 0; VD_i = 24'hFFFFFF; limited_range_i = 0;
    step(2);
    chk("lr_mid", 32'(VD_o), 32'h101010);
    vs_pulse();
    step(8);
    chk("fr_blank", 32'(VD_o), 32'h000000);

    // Mute handshake.
    DE_i = 1; VD_i = 24'h5A5A5A; mute_req_i = 1;
    step(3);
    chk("mreq_vd",  32'(VD_o), 32'h5A5A5A);
    chk("mreq_ack", 32'(mute_ack_o), 32'h0);
    vs_pulse();
    step(1);
    chk("medge_vd",  32'(VD_o), 32'h5A5A5A);
    chk("medge_ack", 32'(mute_ack_o), 32'h1);
    step(1);
    chk("muted_vd", 32'(VD_o), 32'h0);
    chk("muted_de", 32'(DE_o), 32'h1);
    DE_i = 0;
    step(2);
    chk("muted_de0", 32'(DE_o), 32'h0);
    DE_i = 1;
    step(2);
    chk("muted_de1", 32'(DE_o), 32'h1);
    chk("muted_vd1", 32'(VD_o), 32'h0);
    mute_req_i = 0;
    step(3);
    chk("unpend_vd",  32'(VD_o), 32'h0);
    chk("unpend_ack", 32'(mute_ack_o), 32'h1);
    vs_pulse();
    step(1);
    chk("unedge_vd",  32'(VD_o), 32'h0);
    chk("unedge_ack", 32'(mute_ack_o), 32'h0);
    step(1);
    chk("unmuted_vd", 32'(VD_o), 32'h5A5A5A);

    // Aborted mute request: nothing blanked.
    mute_req_i = 1;
    step(2);
    mute_req_i = 0;
    step(2);
    vs_pulse();
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("abort_vd",  32'(VD_o), 32'h5A5A5A);
      chk("abort_ack", 32'(mute_ack_o), 32'h0);
    end

    // Drop and re-raise while muted: stays muted across the edge.
    mute_req_i = 1;
    step(2);
    vs_pulse();
    step(3);
    chk("remute_ack", 32'(mute_ack_o), 32'h1);
    chk("remute_vd",  32'(VD_o), 32'h0);
    mute_req_i = 0;
    step(2);
    mute_req_i = 1;
    step(1);
    vs_pulse();
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("stay_vd", 32'(VD_o), 32'h0);
    end
    chk("stay_ack", 32'(mute_ack_o), 32'h1);

    // Reset while muted with skew 5 and HSYNC inverted.
    sync_skew_i = 3'd5;
    vs_pulse();
    step(8);
    chk("pre_rst_hs", 32'(HSYNC_o), 32'h1);
    HDMI_nRST_w = 1'b0;
    #1;
    chk("arst_hs",  32'(HSYNC_o), 32'h0);
    chk("arst_de",  32'(DE_o), 32'h0);
    chk("arst_ack", 32'(mute_ack_o), 32'h0);
    chk("arst_vd",  32'(VD_o), 32'h0);
    step(2);
    HDMI_nRST_w = 1'b1;
    HSYNC_i = 1; DE_i = 1; VD_i = 24'h0F0F0F;
    step(1);
    HSYNC_i = 0; DE_i = 0;
    step(1);
    chk("post_hs2",  32'(HSYNC_o), 32'h1);
    chk("post_vd2",  32'(VD_o), 32'h0F0F0F);
    chk("post_ack",  32'(mute_ack_o), 32'h0);
    step(1);
    chk("post_hs3",  32'(HSYNC_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/n64adv2_vout_stage.md
# n64adv2_vout_stage

Parametrised output stage for the ADV7513 video interface. It sits between the PPU video outputs and the `VSYNC_o/HSYNC_o/DE_o/VD_o` pads and replaces plain output registering with the following:
- a fixed-depth data pipeline;
- run-time sync-to-data skew alignment;
- sync polarity inversion;
- range-aware blanking;
- a frame-aligned mute handshake.

All run-time configuration is shadowed and only takes effect at a VSYNC boundary.

## Interface
Parameters:
- `COLOR_W`, 8: bits per colour channel (≥8).
- `N_CH`, 3: number of colour channels.
- `PIPE_DEPTH`, 2: data/DE pipeline depth in cycles (1..8). The final stage is the output register.
- `SKEW_W`, 3: width of the skew control. `SKEW_MAX = 2^SKEW_W-1`.

Ports:
- `HDMI_CLK_w` in 1: video Tx clock.
- `HDMI_nRST_w` in 1: reset, asynchronous, active-low. Clock is HDMI_CLK_w.
- `VSYNC_i`, `HSYNC_i`, `DE_i` in 1 each: PPU timing, active-high.
- `VD_i` in N_CH*COLOR_W: pixel data, channel 0 in the LSBs.
- `sync_skew_i` in SKEW_W: extra sync delay relative to DE/VD.
- `vs_inv_i`, `hs_inv_i` in 1: invert VSYNC_o / HSYNC_o.
- `limited_range_i` in 1: blanking value is 16<<(COLOR_W-8) per channel; otherwise 0.
- `mute_req_i` in 1: level request to blank active video.
- `mute_ack_o` out 1: muting is in effect.
- `VSYNC_o`, `HSYNC_o`, `DE_o` out 1 each: registered outputs.
- `VD_o` out N_CH*COLOR_W: registered output data.

## Operation
**VSYNC edge (`vs_edge`)**
- Asserted when VSYNC_i=1 and the registered previous VSYNC_i=0.
- Evaluated on the input side and used for both configuration shadowing and the mute FSM.

**Configuration shadowing**
- On the `vs_edge` cycle, `sync_skew_i`, `vs_inv_i`, `hs_inv_i` and `limited_range_i` load into active registers.
- Reset value of the active registers: skew 0, no inversion, full range.
- Input changes mid-frame have no effect until the next `vs_edge`.

**Data path**
- DE_i, VD_i and a per-pixel mute flag travel through a PIPE_DEPTH-stage shift register.
- At the output stage, VD_o = blank value if the delayed DE=0 or the delayed mute flag=1. Otherwise VD_o = delayed VD_i.
- DE_o = delayed DE_i. DE is never forced low by mute.

**Sync path**
- HSYNC_i and VSYNC_i enter a delay line of length PIPE_DEPTH+SKEW_MAX.
- The tap is selected by the active skew, giving a total latency of PIPE_DEPTH+skew.
- Outputs are XORed with the active inversion bits in the output register.

**Mute FSM**, states RUN, MUTE_PEND, MUTED, UNMUTE_PEND. Reset state is RUN.
- RUN → MUTE_PEND when mute_req_i=1.
- MUTE_PEND → MUTED on `vs_edge`. MUTE_PEND → RUN when mute_req_i=0 before the edge.
- MUTED → UNMUTE_PEND when mute_req_i=0.
- UNMUTE_PEND → RUN on `vs_edge`. UNMUTE_PEND → MUTED when mute_req_i=1 before the edge.
- If mute_req_i and `vs_edge` are high in the same cycle while in RUN, the FSM goes to MUTE_PEND only. Muting begins at the following `vs_edge`.
- The mute flag entering the pipeline is 1 in MUTED and UNMUTE_PEND, using the registered (pre-transition) state. It therefore changes exactly at the first pixel after `vs_edge`.
- mute_ack_o = 1 in MUTED and UNMUTE_PEND, registered from the state. It rises in the cycle after the FSM enters MUTED.

## Timing
**Reset values:** VSYNC_o=0, HSYNC_o=0, DE_o=0, VD_o=0, mute_ack_o=0. All pipeline and delay-line stages are 0. FSM is in RUN.
- The first cycle after reset release outputs VD_o=0 even if the latched range is limited; the blank value applies once the output stage is clocked.

**Latency:**
- DE_o and VD_o: PIPE_DEPTH cycles.
- HSYNC_o and VSYNC_o: PIPE_DEPTH+skew cycles.

**Skew change at `vs_edge`:** the tap switches in the same cycle. The sync pulse in flight may be lengthened or shortened by |Δskew| cycles once. This is accepted behaviour.

**Inversion change:** applies from the cycle after `vs_edge`. A one-cycle level glitch at the switch point is acceptable.

**Reset mid-frame:** all outputs drop to their reset values immediately (asynchronously). Operation resumes on the next input timing, with default configuration until the first `vs_edge`.

**Blank value:** constant per channel. For COLOR_W=10 in limited range it is 64.

## Test plan
- **Reset:** hold HDMI_nRST_w=0 with active stimulus. All outputs are 0 and mute_ack_o=0. After release with PIPE_DEPTH=2 and skew 0, a pixel 0xABCDEF with DE=1 appears on VD_o exactly 2 cycles later.
- **Skew:** active skew 3, HSYNC_i pulse at cycle N. HSYNC_o rises at N+5 and DE_o keeps latency 2. Set hs_inv_i=1 mid-frame: no change until after the next `vs_edge`, then HSYNC_o is idle-high.
- **Limited-range blanking:** limited_range=1 latched, DE_i=0 with VD_i=0xFFFFFF. VD_o=0x101010. With full range, VD_o=0x000000.
- **Mute handshake:** raise mute_req_i mid-frame. Pixels stay unchanged until `vs_edge`. The first DE pixel afterwards is blank, mute_ack_o=1, DE_o still toggles. Drop mute_req_i: video returns on the first pixel after the next `vs_edge` and mute_ack_o falls then.
- **Aborted mute:** pulse mute_req_i high then low before any `vs_edge`. No pixel is blanked and mute_ack_o stays 0. In MUTED, drop and re-raise mute_req_i before `vs_edge`: the FSM stays MUTED and no frame is unblanked.
- **Reset mid-operation:** assert reset in MUTED with skew 5. Outputs go to 0 immediately. After release, mute_ack_o=0 and sync latency is PIPE_DEPTH until the next `vs_edge`.
